// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter sequencing states: accept, wait on memory, deliver response.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Requester identity, used both for the owner of the access and for the
    // round-robin history.
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    localparam int DEFAULT_ADDR_W  = 16;
    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the
// requester that did not win last time is chosen. Nothing is granted while
// enable is low.
module mem_port_arbiter_rr
    import mem_port_arbiter_pkg::*;
(
    input  logic enable,
    input  logic f_valid,
    input  logic d_valid,
    input  logic last_grant,   // 1 = data path won last, 0 = fetch won last
    output logic grant_f,
    output logic grant_d
);

    logic last_was_data;

    assign last_was_data = (last_grant == logic'(REQ_DATA));

    // Grant decode: fetch wins alone or on a tie after a data grant.
    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (enable) begin
            grant_f = f_valid && (!d_valid || last_was_data);
            grant_d = d_valid && (!f_valid || !last_was_data);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch unit and the data path.
// One access is outstanding at a time: IDLE accepts a request, BUSY holds the
// memory strobe until ack or timeout, RESP pulses the owner's response valid.
//
// Handshake: a requester holds *_valid with its payload stable; *_ready is a
// combinational same-cycle accept that is only ever raised in IDLE (and not
// under halt). Responses are one-cycle *_rsp_valid pulses, with rsp_rdata and
// rsp_err meaningful only in that cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              halt,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,
    output logic              f_rsp_valid,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              err_sticky,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    req_id_t           last_grant;
    req_id_t           owner;
    logic [CNT_W-1:0]  cnt;
    logic              arb_en;
    logic              grant_f;
    logic              grant_d;
    logic              grant_any;
    logic              timeout_hit;

    // New grants only from IDLE and only while the core is not halted.
    assign arb_en      = (state == ARB_IDLE) && !halt;
    assign grant_any   = grant_f || grant_d;
    // The last BUSY cycle before giving up; an ack here still wins.
    assign timeout_hit = (cnt == CNT_LAST);
    assign dbg_state   = state;

    mem_port_arbiter_rr u_rr (
        .enable     (arb_en),
        .f_valid    (f_valid),
        .d_valid    (d_valid),
        .last_grant (logic'(last_grant)),
        .grant_f    (grant_f),
        .grant_d    (grant_d)
    );

    // State register; reset drops straight back to IDLE, killing any access.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the IDLE -> BUSY -> RESP loop.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: if (grant_any)               state_next = ARB_BUSY;
            ARB_BUSY: if (mem_ack || timeout_hit)  state_next = ARB_RESP;
            ARB_RESP:                              state_next = ARB_IDLE;
            default:                               state_next = ARB_IDLE;
        endcase
    end

    // Outputs decoded from state: accepts, memory strobe, response pulses.
    always_comb begin
        f_ready     = grant_f;
        d_ready     = grant_d;
        mem_req     = (state == ARB_BUSY);
        f_rsp_valid = (state == ARB_RESP) && (owner == REQ_FETCH);
        d_rsp_valid = (state == ARB_RESP) && (owner == REQ_DATA);
    end

    // Capture the winning request; fetch is always a read with zero data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_grant <= REQ_DATA;
            owner      <= REQ_FETCH;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (grant_any) begin
            last_grant <= grant_d ? REQ_DATA : REQ_FETCH;
            owner      <= grant_d ? REQ_DATA : REQ_FETCH;
            mem_we     <= grant_d && d_we;
            mem_addr   <= grant_d ? d_addr : f_addr;
            mem_wdata  <= grant_d ? d_wdata : '0;
        end
    end

    // Cycles spent in BUSY; cleared everywhere else.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (state == ARB_BUSY) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Response data/error, latched when BUSY completes by ack or timeout.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else if (state == ARB_BUSY) begin
            if (mem_ack) begin
                rsp_rdata <= mem_we ? '0 : mem_rdata;
                rsp_err   <= 1'b0;
            end else if (timeout_hit) begin
                rsp_rdata  <= '0;
                rsp_err    <= 1'b1;
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory responder, a transaction-level
// scoreboard and one task per scenario.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        halt = 1'b0;
    logic        f_valid = 1'b0;
    logic [15:0] f_addr = '0;
    logic        d_valid = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        f_ready, f_rsp_valid, d_ready, d_rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err, err_sticky, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;

    // Responder controls
    int ack_lat = 1;
    bit rand_lat = 1'b0;
    bit no_ack = 1'b0;
    bit spur_ack = 1'b0;
    int busy_cyc = 0;
    int cur_lat = 0;

    // Memory macro contents (responder) and reference view (model)
    logic [15:0] mem_arr [logic [15:0]];
    logic [15:0] mem_ref [logic [15:0]];

    // Scoreboard: {owner(1=data), err, rdata}
    logic [17:0] exp_q [$];
    logic        m_last;
    logic        m_sticky;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .halt        (halt),
        .f_valid     (f_valid),
        .f_addr      (f_addr),
        .f_ready     (f_ready),
        .f_rsp_valid (f_rsp_valid),
        .d_valid     (d_valid),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .d_rsp_valid (d_rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .err_sticky  (err_sticky),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] arr_read(input logic [15:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_val(a);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (mem_ref.exists(a)) return mem_ref[a];
        return init_val(a);
    endfunction

    // Memory responder: acks on the cur_lat-th cycle of mem_req, updates
    // its contents on store acks, drives junk read data otherwise.
    always begin
        @(posedge clk);
        #1;
        if (!mem_req) begin
            busy_cyc  = 0;
            mem_ack   = spur_ack;
            mem_rdata = 16'($urandom);
        end else begin
            if (busy_cyc == 0) cur_lat = rand_lat ? $urandom_range(1, 6) : ack_lat;
            busy_cyc++;
            if (!no_ack && busy_cyc == cur_lat) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    mem_rdata = 16'($urandom);
                end else begin
                    mem_rdata = arr_read(mem_addr);
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end
    end

    // Scoreboard: predicts accepts from the arbitration rules, queues the
    // expected response of each accepted request, and checks every response.
    always @(negedge clk) begin : sb
        logic        exp_f, exp_d, e_we, e_err;
        logic [15:0] e_addr, e_rdata;
        logic [17:0] e;
        if (!n_rst) begin
            exp_q.delete();
            m_last   = 1'b1;
            m_sticky = 1'b0;
        end else begin
            exp_f = !halt && (exp_q.size() == 0) && f_valid && (!d_valid || m_last);
            exp_d = !halt && (exp_q.size() == 0) && d_valid && !exp_f;
            total++;
            if ({f_ready, d_ready} !== {exp_f, exp_d}) begin
                bad++;
                $display("FAIL grant: f_ready,d_ready=%b%b required %b%b at %0t",
                         f_ready, d_ready, exp_f, exp_d, $time);
            end
            if (f_rsp_valid || d_rsp_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: f_rsp_valid=%b d_rsp_valid=%b required none at %0t",
                             f_rsp_valid, d_rsp_valid, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e[16]) m_sticky = 1'b1;
                    if ({f_rsp_valid, d_rsp_valid, rsp_err, rsp_rdata, err_sticky} !==
                        {~e[17], e[17], e[16], e[15:0], m_sticky}) begin
                        bad++;
                        $display("FAIL rsp: f/d=%b%b err=%b rdata=%h sticky=%b required f/d=%b%b err=%b rdata=%h sticky=%b at %0t",
                                 f_rsp_valid, d_rsp_valid, rsp_err, rsp_rdata, err_sticky,
                                 ~e[17], e[17], e[16], e[15:0], m_sticky, $time);
                    end
                end
            end
            if (exp_f || exp_d) begin
                e_we    = exp_d && d_we;
                e_addr  = exp_d ? d_addr : f_addr;
                e_err   = no_ack || (!rand_lat && ack_lat > TIMEOUT);
                e_rdata = (e_err || e_we) ? 16'h0000 : ref_read(e_addr);
                if (!e_err && e_we) mem_ref[e_addr] = d_wdata;
                exp_q.push_back({exp_d, e_err, e_rdata});
                m_last = exp_d;
            end
        end
    end

    // Driver: present a fetch until accepted, then drop it.
    task automatic issue_f(input logic [15:0] a);
        int n;
        n = 0;
        @(posedge clk); #1;
        f_valid = 1'b1;
        f_addr  = a;
        @(negedge clk);
        while (!f_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!f_ready) begin
            bad++;
            $display("FAIL issue_f: f_ready=0 after %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        f_valid = 1'b0;
    endtask

    // Driver: present a data request until accepted, then drop it.
    task automatic issue_d(input logic we, input logic [15:0] a, input logic [15:0] wd);
        int n;
        n = 0;
        @(posedge clk); #1;
        d_valid = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        @(negedge clk);
        while (!d_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!d_ready) begin
            bad++;
            $display("FAIL issue_d: d_ready=0 after %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        d_valid = 1'b0;
        d_we    = 1'b0;
    endtask

    // Wait until every accepted request has been answered.
    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (exp_q.size() != 0 && n < 400);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({f_ready, d_ready, f_rsp_valid, d_rsp_valid, rsp_err, err_sticky, mem_req, mem_we} !== 8'h00) begin
            bad++;
            $display("FAIL reset_flags_in_reset: %b required 00000000",
                     {f_ready, d_ready, f_rsp_valid, d_rsp_valid, rsp_err, err_sticky, mem_req, mem_we});
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk);
        total++;
        if ({f_ready, d_ready, f_rsp_valid, d_rsp_valid, rsp_err, err_sticky, mem_req, mem_we} !== 8'h00) begin
            bad++;
            $display("FAIL reset_flags: %b required 00000000",
                     {f_ready, d_ready, f_rsp_valid, d_rsp_valid, rsp_err, err_sticky, mem_req, mem_we});
        end
        total++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 48'h0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0", mem_addr, mem_wdata, rsp_rdata);
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: %0d required 0", dbg_state);
        end
    endtask

    task automatic test_single_fetch();
        logic [15:0] exp_data;
        ack_lat  = 2;
        rand_lat = 1'b0;
        no_ack   = 1'b0;
        exp_data = ref_read(16'h0010);
        @(posedge clk); #1;
        f_valid = 1'b1;
        f_addr  = 16'h0010;
        @(negedge clk);
        total++;
        if ({f_ready, d_ready, mem_req} !== 3'b100) begin
            bad++;
            $display("FAIL fetch_c0: f_ready,d_ready,mem_req=%b required 100", {f_ready, d_ready, mem_req});
        end
        @(posedge clk); #1;
        f_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_req, mem_we, mem_addr, f_rsp_valid} !== {1'b1, 1'b0, 16'h0010, 1'b0}) begin
            bad++;
            $display("FAIL fetch_c1: req=%b we=%b addr=%h rsp=%b required 1 0 0010 0",
                     mem_req, mem_we, mem_addr, f_rsp_valid);
        end
        @(negedge clk);
        total++;
        if ({mem_req, f_rsp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_c2: req,rsp=%b required 10", {mem_req, f_rsp_valid});
        end
        @(negedge clk);
        total++;
        if ({mem_req, f_rsp_valid, d_rsp_valid, rsp_err, rsp_rdata} !== {4'b0100, exp_data}) begin
            bad++;
            $display("FAIL fetch_c3: req=%b f_rsp=%b d_rsp=%b err=%b rdata=%h required 0 1 0 0 %h",
                     mem_req, f_rsp_valid, d_rsp_valid, rsp_err, rsp_rdata, exp_data);
        end
        @(negedge clk);
        total++;
        if (f_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_c4: f_rsp_valid=%b required 0", f_rsp_valid);
        end
    endtask

    task automatic test_contention();
        logic gf, gd, prev_d;
        int   ngr;
        drain();
        ack_lat = 1;
        ngr     = 0;
        prev_d  = 1'b0;
        f_valid = 1'b1;
        f_addr  = 16'($urandom_range(0, 31));
        d_valid = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'($urandom_range(0, 31));
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            gf = f_ready;
            gd = d_ready;
            if (gf || gd) begin
                total++;
                if ((gf && gd) || (ngr > 0 && prev_d == gd)) begin
                    bad++;
                    $display("FAIL alternation: grant %0d f=%b d=%b previous was %s",
                             ngr, gf, gd, prev_d ? "data" : "fetch");
                end
                prev_d = gd;
                ngr++;
            end
            @(posedge clk); #1;
            if (gf) f_addr = 16'($urandom_range(0, 31));
            if (gd) begin
                d_addr  = 16'($urandom_range(0, 31));
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = 16'($urandom);
            end
        end
        f_valid = 1'b0;
        d_valid = 1'b0;
        d_we    = 1'b0;
        // One-cycle IDLE, BUSY and RESP per access: one grant every 3 cycles.
        total++;
        if (ngr != 20) begin
            bad++;
            $display("FAIL contention_count: %0d grants in 60 cycles, required 20", ngr);
        end
        drain();
    endtask

    task automatic test_store();
        int nbusy;
        bit saw;
        drain();
        ack_lat = 3;
        nbusy   = 0;
        saw     = 1'b0;
        @(posedge clk); #1;
        d_valid = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0200;
        d_wdata = 16'hBEEF;
        @(negedge clk);
        total++;
        if (d_ready !== 1'b1) begin
            bad++;
            $display("FAIL store_accept: d_ready=%b required 1", d_ready);
        end
        @(posedge clk); #1;
        d_valid = 1'b0;
        d_we    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req) begin
                nbusy++;
                total++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0200, 16'hBEEF}) begin
                    bad++;
                    $display("FAIL store_busy: we=%b addr=%h wdata=%h required 1 0200 beef",
                             mem_we, mem_addr, mem_wdata);
                end
            end
            if (d_rsp_valid) begin
                saw = 1'b1;
                total++;
                if ({rsp_rdata, rsp_err} !== 17'h0) begin
                    bad++;
                    $display("FAIL store_rsp: rdata=%h err=%b required 0000 0", rsp_rdata, rsp_err);
                end
            end
        end
        total++;
        if (nbusy != 3 || !saw) begin
            bad++;
            $display("FAIL store_len: busy=%0d rsp_seen=%0d required 3 1", nbusy, saw);
        end
        issue_f(16'h0200);
        drain();
    endtask

    task automatic test_timeout();
        int          nreq;
        logic [15:0] exp_data;
        drain();
        no_ack   = 1'b1;
        spur_ack = 1'b1;
        issue_d(1'b0, 16'h0033, 16'h0000);
        nreq = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!mem_req) break;
            nreq++;
        end
        total++;
        if (nreq != TIMEOUT) begin
            bad++;
            $display("FAIL timeout_len: mem_req high %0d cycles, required %0d", nreq, TIMEOUT);
        end
        total++;
        if ({d_rsp_valid, rsp_err, err_sticky, rsp_rdata} !== {3'b111, 16'h0000}) begin
            bad++;
            $display("FAIL timeout_rsp: d_rsp=%b err=%b sticky=%b rdata=%h required 1 1 1 0000",
                     d_rsp_valid, rsp_err, err_sticky, rsp_rdata);
        end
        no_ack = 1'b0;
        ack_lat = 1;
        issue_f(16'h0021);
        drain();
        // Ack landing on the last permitted BUSY cycle completes normally.
        ack_lat  = TIMEOUT;
        exp_data = ref_read(16'h0044);
        issue_f(16'h0044);
        nreq = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!mem_req) break;
            nreq++;
        end
        total++;
        if (nreq != TIMEOUT) begin
            bad++;
            $display("FAIL late_ack_len: mem_req high %0d cycles, required %0d", nreq, TIMEOUT);
        end
        total++;
        if ({f_rsp_valid, rsp_err, err_sticky, rsp_rdata} !== {3'b101, exp_data}) begin
            bad++;
            $display("FAIL late_ack_rsp: f_rsp=%b err=%b sticky=%b rdata=%h required 1 0 1 %h",
                     f_rsp_valid, rsp_err, err_sticky, rsp_rdata, exp_data);
        end
        spur_ack = 1'b0;
        ack_lat  = 1;
        drain();
    endtask

    task automatic test_reset_mid();
        drain();
        ack_lat = 5;
        issue_f(16'h0055);
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        total++;
        if ({mem_req, f_rsp_valid, d_rsp_valid, dbg_state} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid: req=%b f_rsp=%b d_rsp=%b state=%0d required 0 0 0 0",
                     mem_req, f_rsp_valid, d_rsp_valid, dbg_state);
        end
        @(posedge clk); #1;
        n_rst   = 1'b1;
        ack_lat = 2;
        f_valid = 1'b1;
        f_addr  = 16'h0066;
        d_valid = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0077;
        @(negedge clk);
        total++;
        if ({f_ready, d_ready, err_sticky} !== 3'b100) begin
            bad++;
            $display("FAIL reset_first_grant: f_ready,d_ready,err_sticky=%b required 100",
                     {f_ready, d_ready, err_sticky});
        end
        @(posedge clk); #1;
        f_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 30 && !d_ready; c++) @(negedge clk);
        total++;
        if (d_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_second_grant: d_ready=%b required 1", d_ready);
        end
        @(posedge clk); #1;
        d_valid = 1'b0;
        drain();
    endtask

    task automatic test_halt();
        bit got;
        drain();
        ack_lat = 3;
        got     = 1'b0;
        @(posedge clk); #1;
        f_valid = 1'b1;
        f_addr  = 16'h0088;
        @(negedge clk);
        total++;
        if (f_ready !== 1'b1) begin
            bad++;
            $display("FAIL halt_first: f_ready=%b required 1", f_ready);
        end
        @(posedge clk); #1;
        halt    = 1'b1;
        f_addr  = 16'h0099;
        d_valid = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h00AA;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (f_rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL halt_rsp: f_rsp_valid never seen, required one pulse");
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({f_ready, d_ready} !== 2'b00) begin
                bad++;
                $display("FAIL halt_park: f_ready,d_ready=%b%b required 00", f_ready, d_ready);
            end
        end
        @(posedge clk); #1;
        halt = 1'b0;
        @(negedge clk);
        total++;
        if ({f_ready, d_ready} !== 2'b01) begin
            bad++;
            $display("FAIL halt_release: f_ready,d_ready=%b%b required 01", f_ready, d_ready);
        end
        @(posedge clk); #1;
        d_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 30 && !f_ready; c++) @(negedge clk);
        total++;
        if (f_ready !== 1'b1) begin
            bad++;
            $display("FAIL halt_fetch_after: f_ready=%b required 1", f_ready);
        end
        @(posedge clk); #1;
        f_valid = 1'b0;
        drain();
    endtask

    task automatic test_random();
        logic fa, da;
        drain();
        rand_lat = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            fa = f_ready;
            da = d_ready;
            @(posedge clk); #1;
            if (!f_valid || fa) begin
                f_valid = ($urandom_range(0, 2) != 0);
                f_addr  = 16'($urandom_range(0, 15));
            end
            if (!d_valid || da) begin
                d_valid = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 16'($urandom_range(0, 15));
                d_wdata = 16'($urandom);
            end
            halt = ($urandom_range(0, 9) == 0);
        end
        f_valid = 1'b0;
        d_valid = 1'b0;
        d_we    = 1'b0;
        halt    = 1'b0;
        drain();
        rand_lat = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_timeout();
        test_reset_mid();
        test_halt();
        test_random();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
